mem_bus_master: RTL

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

---
 rtl/mem_bus_pkg.sv | 25 ++
 rtl/bus_timer.sv | 30 +++
 rtl/mem_bus_master.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the parallel memory bus: cycle types and master FSM states.
// Pure definitions; no logic, latency or flow control of its own.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_CONFIG = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_e;

    // The reserved encoding behaves as a read on the bus.
    function automatic logic op_is_read(input op_e op_val);
        return (op_val == OP_READ) || (op_val == OP_RSVD);
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Cycle counter for the strobe/release windows; expired when the count reaches TIMEOUT-1.
// Latency 0 from count to expired; the count holds at the limit until cleared.
module bus_timer #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic reset_,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mem_bus_master.sv
// Single-transfer master for an active-low strobe/acknowledge bus; req to done is 4 clocks minimum.
// No queueing: req is only sampled in IDLE, and a silent responder is aborted after TIMEOUT strobe cycles.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [3:0]  nb,
    input  logic [15:0] ad,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        no_answer,
    output logic [15:0] rdata,
    output logic [3:0]  nb_,
    output logic [15:0] ad_,
    output logic [15:0] rdt_,
    output logic        r_,
    output logic        w_,
    output logic        s_,
    input  logic [15:0] ddt_,
    input  logic        ok_
);

    state_e      state, next;
    op_e         op_q;
    logic [3:0]  nb_q;
    logic [15:0] ad_q;
    logic [15:0] wdata_q;
    logic        no_ans_q;
    logic        drive_bus;
    logic        tmr_clear;
    logic        tmr_en;
    logic        tmr_expired;

    bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_  (reset_),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Bus outputs decode only registered state, so ok_ never reaches them combinationally.
    always_comb begin
        next      = state;
        drive_bus = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        no_answer = 1'b0;
        nb_       = '1;
        ad_       = '1;
        rdt_      = '1;
        r_        = 1'b1;
        w_        = 1'b1;
        s_        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req) next = SETUP;
            end
            SETUP: begin
                drive_bus = 1'b1;
                tmr_clear = 1'b1;
                next      = STROBE;
            end
            STROBE: begin
                drive_bus = 1'b1;
                tmr_en    = 1'b1;
                case (op_q)
                    OP_WRITE:  w_ = 1'b0;
                    OP_CONFIG: s_ = 1'b0;
                    default:   r_ = 1'b0;
                endcase
                if (!ok_ || tmr_expired) begin
                    tmr_clear = 1'b1;
                    next      = RELEASE;
                end
            end
            RELEASE: begin
                drive_bus = 1'b1;
                tmr_en    = 1'b1;
                if (ok_ || tmr_expired) next = DONE;
            end
            DONE: begin
                done      = 1'b1;
                no_answer = no_ans_q;
                next      = IDLE;
            end
            default: next = IDLE;
        endcase
        if (drive_bus) begin
            nb_  = ~nb_q;
            ad_  = ~ad_q;
            rdt_ = op_is_read(op_q) ? 16'hFFFF : ~wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            op_q     <= OP_READ;
            nb_q     <= '0;
            ad_q     <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
            no_ans_q <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                op_q     <= op_e'(op);
                nb_q     <= nb;
                ad_q     <= ad;
                wdata_q  <= wdata;
                no_ans_q <= 1'b0;
            end
            // An acknowledge on the expiry cycle still counts as an answer.
            if (state == STROBE) begin
                if (!ok_) begin
                    if (op_is_read(op_q)) rdata <= ~ddt_;
                end else if (tmr_expired) begin
                    no_ans_q <= 1'b1;
                end
            end
        end
    end

endmodule
